// File: rtl/r_bin_pkg.sv
// r_bin_pkg: shared widths, beat type and helpers for the r-bin quantiser
package r_bin_pkg;
  localparam int PROD_W = 33;
  localparam int BIN_W = 6;
  localparam int THETA_W = 7;
  localparam int SUM_W = 35;
  localparam int CNT_W = 16;
  localparam logic signed [SUM_W-1:0] BIN_MAX = SUM_W'(2**BIN_W - 1);
  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic hit;
    logic [THETA_W-1:0] theta;
    logic last;
  } r_bin_beat_t;
  function automatic logic [SUM_W-1:0] sext(input logic [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction
  function automatic logic [BIN_W:0] sat_bin(input logic signed [SUM_W-1:0] q);
    return q < 0 ? {(BIN_W+1){1'b0}} : q > BIN_MAX ? {{BIN_W{1'b1}}, 1'b0} : {q[BIN_W-1:0], 1'b1};
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    return cnt + CNT_W'(inc && cnt != '1);
  endfunction
endpackage

// File: rtl/r_bin_quantize_if.sv
// r_bin_quantize_if: product input stream, bin output stream and frame statistics
interface r_bin_quantize_if;
  import r_bin_pkg::*;
  logic s_valid;
  logic s_ready;
  logic [PROD_W-1:0] s_prod_x;
  logic [PROD_W-1:0] s_prod_y;
  logic [THETA_W-1:0] s_theta;
  logic s_last;
  logic m_valid;
  logic m_ready;
  logic [BIN_W-1:0] m_bin;
  logic m_hit;
  logic [THETA_W-1:0] m_theta;
  logic m_last;
  logic stat_valid;
  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_oor;
  modport slave (
    input s_valid, s_prod_x, s_prod_y, s_theta, s_last, m_ready,
    output s_ready, m_valid, m_bin, m_hit, m_theta, m_last, stat_valid, stat_hits, stat_oor
  );
  modport master (
    output s_valid, s_prod_x, s_prod_y, s_theta, s_last, m_ready,
    input s_ready, m_valid, m_bin, m_hit, m_theta, m_last, stat_valid, stat_hits, stat_oor
  );
endinterface

// File: rtl/r_bin_frame_stats.sv
// r_bin_frame_stats: per-frame saturating hit/out-of-range counters with end-of-frame pulse
module r_bin_frame_stats
  import r_bin_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic xfer,
  input  logic hit,
  input  logic last,
  output logic stat_valid,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_oor
);
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, oor_cnt_q, oor_cnt_d, hits_nx, oor_nx;
  logic [CNT_W-1:0] stat_hits_q, stat_hits_d, stat_oor_q, stat_oor_d;
  logic stat_valid_q, stat_valid_d, frame_end;
  always_comb begin
    hits_nx = sat_inc(hit_cnt_q, xfer && hit);
    oor_nx = sat_inc(oor_cnt_q, xfer && !hit);
    frame_end = xfer && last;
    hit_cnt_d = frame_end ? '0 : hits_nx;
    oor_cnt_d = frame_end ? '0 : oor_nx;
    stat_valid_d = frame_end;
    stat_hits_d = frame_end ? hits_nx : stat_hits_q;
    stat_oor_d = frame_end ? oor_nx : stat_oor_q;
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      hit_cnt_q <= '0;
      oor_cnt_q <= '0;
      stat_valid_q <= 1'b0;
      stat_hits_q <= '0;
      stat_oor_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      oor_cnt_q <= oor_cnt_d;
      stat_valid_q <= stat_valid_d;
      stat_hits_q <= stat_hits_d;
      stat_oor_q <= stat_oor_d;
    end
  end
  assign stat_valid = stat_valid_q;
  assign stat_hits = stat_hits_q;
  assign stat_oor = stat_oor_q;
endmodule

// File: rtl/r_bin_quantize.sv
// r_bin_quantize: two-stage sum/round/saturate of theta-slot products into r-bin indices
module r_bin_quantize
  import r_bin_pkg::*;
#(
  parameter int SHIFT = 20,
  parameter logic signed [SUM_W-1:0] R_OFFSET = '0
) (
  input logic ap_clk,
  input logic ap_rst_n,
  r_bin_quantize_if.slave bus
);
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(64'd1 << (SHIFT - 1));
  logic en, v1_q, v1_d, v2_q, v2_d, last_q, last_d;
  logic signed [SUM_W-1:0] sum_q, sum_d, q;
  logic [THETA_W-1:0] theta_q, theta_d;
  logic [BIN_W:0] sb;
  r_bin_beat_t beat_q, beat_d;
  logic stat_valid;
  logic [CNT_W-1:0] stat_hits, stat_oor;
  always_comb begin
    en = !v2_q || bus.m_ready;
    q = sum_q >>> SHIFT;
    sb = sat_bin(q);
    v1_d = en ? bus.s_valid : v1_q;
    sum_d = en ? sext(bus.s_prod_x) + sext(bus.s_prod_y) + R_OFFSET + HALF : sum_q;
    theta_d = en ? bus.s_theta : theta_q;
    last_d = en ? bus.s_last : last_q;
    v2_d = en ? v1_q : v2_q;
    beat_d = en ? r_bin_beat_t'{bin: sb[BIN_W:1], hit: sb[0], theta: theta_q, last: last_q} : beat_q;
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      v1_q <= 1'b0;
      sum_q <= '0;
      theta_q <= '0;
      last_q <= 1'b0;
      v2_q <= 1'b0;
      beat_q <= '0;
    end else begin
      v1_q <= v1_d;
      sum_q <= sum_d;
      theta_q <= theta_d;
      last_q <= last_d;
      v2_q <= v2_d;
      beat_q <= beat_d;
    end
  end
  r_bin_frame_stats u_stats (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .xfer(v2_q && bus.m_ready),
    .hit(beat_q.hit),
    .last(beat_q.last),
    .stat_valid(stat_valid),
    .stat_hits(stat_hits),
    .stat_oor(stat_oor)
  );
  assign bus.s_ready = en;
  assign bus.m_valid = v2_q;
  assign bus.m_bin = beat_q.bin;
  assign bus.m_hit = beat_q.hit;
  assign bus.m_theta = beat_q.theta;
  assign bus.m_last = beat_q.last;
  assign bus.stat_valid = stat_valid;
  assign bus.stat_hits = stat_hits;
  assign bus.stat_oor = stat_oor;
endmodule

// File: tb/tb_r_bin_quantize.sv
// tb_r_bin_quantize: vector table, hand sequences and random stream against a behavioural model
module tb_r_bin_quantize;
  import r_bin_pkg::*;
  localparam int SHIFT = 20;
  localparam longint R_OFF = 0;
  typedef struct {longint x; longint y; int th; bit lst; int bin; bit hit;} vec_t;
  typedef struct {int bin; bit hit; int th; bit lst;} exp_t;
  typedef struct {int h; int o;} stat_t;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  r_bin_quantize_if bus();
  r_bin_quantize #(.SHIFT(SHIFT), .R_OFFSET(SUM_W'(R_OFF))) dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));
  always #5 ap_clk = ~ap_clk;
  exp_t exp_q[$];
  stat_t stat_log[$];
  int errors = 0, checks = 0, xfers = 0, rmode = 0;
  int hc = 0, oc = 0, ph = 0, po = 0, lh = 0, lo = 0;
  bit pend = 0, held = 0;
  logic [BIN_W+THETA_W+1:0] hbeat;
  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask
  function automatic exp_t model(input longint x, input longint y, input int th, input bit lst);
    longint t, unit, qq;
    exp_t e;
    unit = 64'sd1 <<< SHIFT;
    t = x + y + R_OFF + unit / 2;
    qq = t / unit;
    if (t < 0 && t % unit != 0) qq = qq - 1;
    e.th = th;
    e.lst = lst;
    e.hit = qq >= 0 && qq < 2**BIN_W;
    e.bin = qq < 0 ? 0 : qq >= 2**BIN_W ? 2**BIN_W - 1 : int'(qq);
    return e;
  endfunction
  task automatic send(input longint x, input longint y, input int th, input bit lst, input exp_t e);
    bit acc;
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_prod_x = PROD_W'(x);
    bus.s_prod_y = PROD_W'(y);
    bus.s_theta = THETA_W'(th);
    bus.s_last = lst;
    do begin
      @(negedge ap_clk);
      acc = bus.s_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("accept", acc, 1);
    if (acc) exp_q.push_back(e);
    bus.s_valid = 1'b0;
  endtask
  task automatic send_v(input vec_t v);
    exp_t e;
    e = '{v.bin, v.hit, v.th, v.lst};
    send(v.x, v.y, v.th, v.lst, e);
  endtask
  task automatic send_m(input longint x, input longint y, input int th, input bit lst);
    send(x, y, th, lst, model(x, y, th, lst));
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask
  task automatic do_reset();
    ap_rst_n = 1'b0;
    bus.s_valid = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_bin", bus.m_bin, 0);
    check("rst_m_hit", bus.m_hit, 0);
    check("rst_m_theta", bus.m_theta, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_stat_valid", bus.stat_valid, 0);
    check("rst_stat_hits", bus.stat_hits, 0);
    check("rst_stat_oor", bus.stat_oor, 0);
    check("rst_s_ready", bus.s_ready, 1);
    @(posedge ap_clk);
    #1;
  endtask
  initial begin
    int rc = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #2;
      rc++;
      bus.m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (rc % 3 == 0) : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        exp_q.delete();
        hc = 0; oc = 0; pend = 0; held = 0; lh = 0; lo = 0;
        continue;
      end
      if (pend) begin
        lh = ph;
        lo = po;
      end
      check("stat_valid", bus.stat_valid, pend);
      check("stat_hits", bus.stat_hits, lh);
      check("stat_oor", bus.stat_oor, lo);
      if (bus.stat_valid) stat_log.push_back('{int'(bus.stat_hits), int'(bus.stat_oor)});
      check("s_ready", bus.s_ready, !bus.m_valid || bus.m_ready);
      if (held) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_beat", {bus.m_bin, bus.m_hit, bus.m_theta, bus.m_last}, hbeat);
      end
      held = bus.m_valid && !bus.m_ready;
      hbeat = {bus.m_bin, bus.m_hit, bus.m_theta, bus.m_last};
      pend = 0;
      if (bus.m_valid && bus.m_ready) begin
        xfers++;
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_bin", bus.m_bin, e.bin);
          check("m_hit", bus.m_hit, e.hit);
          check("m_theta", bus.m_theta, e.th);
          check("m_last", bus.m_last, e.lst);
          if (e.hit) hc = hc < 65535 ? hc + 1 : hc;
          else oc = oc < 65535 ? oc + 1 : oc;
          if (e.lst) begin
            pend = 1; ph = hc; po = oc; hc = 0; oc = 0;
          end
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    vec_t vt[11];
    int start;
    logic [63:0] r;
    logic signed [PROD_W-1:0] rs;
    longint x, y;
    vt[0] = '{5242880, 3145728, 17, 1'b0, 8, 1'b1};
    vt[1] = '{524288, 0, 1, 1'b0, 1, 1'b1};
    vt[2] = '{524287, 0, 2, 1'b0, 0, 1'b1};
    vt[3] = '{-524288, 0, 3, 1'b0, 0, 1'b1};
    vt[4] = '{-524289, 0, 4, 1'b0, 0, 1'b0};
    vt[5] = '{33554432, 33554432, 5, 1'b0, 63, 1'b0};
    vt[6] = '{-64'sd4294967296, -64'sd4294967296, 6, 1'b0, 0, 1'b0};
    vt[7] = '{64'sd4294967295, 64'sd4294967295, 7, 1'b0, 63, 1'b0};
    vt[8] = '{66060288, 262144, 8, 1'b0, 63, 1'b1};
    vt[9] = '{66060288, 524288, 9, 1'b0, 63, 1'b0};
    vt[10] = '{20971520, -10485760, 127, 1'b1, 10, 1'b1};
    bus.s_valid = 1'b0;
    bus.s_prod_x = '0;
    bus.s_prod_y = '0;
    bus.s_theta = '0;
    bus.s_last = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    do_reset();
    send_v(vt[0]);
    @(negedge ap_clk);
    check("latency_c1_valid", bus.m_valid, 0);
    @(negedge ap_clk);
    check("latency_c2_valid", bus.m_valid, 1);
    check("basic_bin", bus.m_bin, 8);
    check("basic_theta", bus.m_theta, 17);
    @(posedge ap_clk);
    #1;
    for (int i = 1; i < 11; i++) send_v(vt[i]);
    drain();
    stat_log.delete();
    send_m(64'sd1 << 20, 0, 20, 1'b0);
    send_m(-(64'sd5 << 20), 0, 21, 1'b0);
    send_m(64'sd40 << 20, 0, 22, 1'b0);
    send_m(64'sd100 << 20, 0, 23, 1'b0);
    send_m(64'sd63 << 20, 0, 24, 1'b1);
    send_m(64'sd2 << 20, 0, 25, 1'b0);
    send_m(-(64'sd9 << 20), 0, 26, 1'b1);
    drain();
    check("frame_pulses", stat_log.size(), 2);
    if (stat_log.size() >= 2) begin
      check("frame1_hits", stat_log[0].h, 3);
      check("frame1_oor", stat_log[0].o, 2);
      check("frame2_hits", stat_log[1].h, 1);
      check("frame2_oor", stat_log[1].o, 1);
    end
    rmode = 1;
    start = xfers;
    for (int i = 0; i < 10; i++) send_m((64'sd7 * i - 4) << 20, 64'sd1 << 18, 40 + i, i == 9);
    drain();
    check("bp_beats", xfers - start, 10);
    rmode = 0;
    stat_log.delete();
    send_m(64'sd3 << 20, 0, 50, 1'b0);
    drain();
    rmode = 3;
    @(posedge ap_clk);
    #1;
    send_m(64'sd4 << 20, 0, 51, 1'b0);
    send_m(64'sd99 << 20, 0, 52, 1'b0);
    check("in_flight", exp_q.size(), 2);
    do_reset();
    check("abort_no_stat", stat_log.size(), 0);
    rmode = 0;
    @(posedge ap_clk);
    #1;
    send_m(64'sd6 << 20, 0, 53, 1'b0);
    send_m(64'sd80 << 20, 0, 54, 1'b1);
    drain();
    check("post_rst_pulses", stat_log.size(), 1);
    if (stat_log.size() >= 1) begin
      check("post_rst_hits", stat_log[0].h, 1);
      check("post_rst_oor", stat_log[0].o, 1);
    end
    rmode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge ap_clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0: begin
          r = {$urandom, $urandom};
          rs = r[PROD_W-1:0];
          x = rs;
          r = {$urandom, $urandom};
          rs = r[PROD_W-1:0];
          y = rs;
        end
        1: begin
          x = (longint'($urandom_range(0, 68)) - 2) << 20;
          y = $urandom_range(0, 3) == 0 ? -(64'sd1 << 19) - 1 : $urandom_range(0, 1) ? 64'sd1 << 19 : (64'sd1 << 19) - 1;
        end
        default: begin
          x = longint'($urandom_range(0, 32'd73400320)) - (64'sd4 << 20);
          y = longint'($urandom_range(0, 32'd2097152)) - (64'sd1 << 20);
        end
      endcase
      send_m(x, y, int'($urandom_range(0, 127)), i == 299 || $urandom_range(0, 7) == 0);
    end
    drain();
    rmode = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
